sink_table_search: RTL and testbench
====================================

Name: sink_table_search

Overview:
- Parametrised sequential lookup: determines whether an ID is present in a flattened table of known sink IDs, scanning one entry per clock.
- Adds over the previous-generation sink check: start/done handshake, configurable entry count, early exit, match index, abort.
- Sits between the routing-table storage and cost-evaluation logic; consumers launch a search and wait for a one-cycle done pulse.

Parameters:
- ID_W, 5, width of one sink ID.
- DEPTH, 10, table capacity in entries (must be >= 1).
- IDX_W, 4, width of the entry index; must satisfy 2**IDX_W >= DEPTH.
- CNT_W, 4, width of the entry count; must satisfy 2**CNT_W > DEPTH.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a search; sampled only in IDLE.
- abort  in  1  cancel an in-progress scan.
- arg_id  in  ID_W  ID to search for; latched on accepted start.
- table_flat  in  DEPTH*ID_W  entry i is bits [ID_W*i +: ID_W]; latched on accepted start.
- num_entries  in  CNT_W  number of valid entries, counted from entry 0; latched on accepted start.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse; result valid.
- found  out  1  a match was found.
- match_idx  out  IDX_W  lowest matching index; 0 on miss.
- match_count  out  CNT_W  present only with MATCH_COUNT_EN.

Behaviour:
- Reset, asynchronous, active-high: state=IDLE; busy, done, found, match_idx, match_count and the internal index all go to 0.
- Outputs are registered. States are IDLE and SCAN.
- Effective length: n = min(num_entries, DEPTH), clamped at latch time.
- Edge E0, IDLE with start=1:
  - Latch arg_id, table_flat and n.
  - If n==0: done<=1, found<=0, match_idx<=0; stay in IDLE; busy stays 0.
  - Otherwise: busy<=1, idx<=0, go to SCAN.
- Each edge in SCAN compares entry idx against the latched arg_id:
  - Match (default build): found<=1, match_idx<=idx, done<=1, busy<=0, go to IDLE.
  - No match and idx==n-1: found<=0, match_idx<=0, done<=1, busy<=0, go to IDLE.
  - Otherwise: idx<=idx+1.
- Latency:
  - Match at entry k: done is high in the cycle after edge E0+k+1.
  - Full miss: done is high in the cycle after edge E0+n.
- done is high for exactly one cycle and is cleared on the following edge.
- found and match_idx hold their value until the next done.
- start while in SCAN is ignored, not queued. A start in the same cycle that done is high is accepted, because the state is already IDLE.
- Changes to the input buses after E0 do not affect the running search.
- abort=1 in SCAN: go to IDLE, busy<=0, no done pulse; found and match_idx keep their previous values.
  - abort and a match/end on the same edge: abort wins.
  - abort in IDLE is ignored; start and abort both high in IDLE: start wins.
- Duplicate IDs in the table: the lowest index is reported.
- Reset asserted mid-scan: immediate return to IDLE with reset values; no done pulse.

Optional Feature:
- Macro: SINK_SEARCH_MATCH_COUNT_EN.
- Defined:
  - Port match_count exists.
  - Early exit is disabled: the scan always covers all n entries, so done is high in the cycle after edge E0+n (or after E0 when n==0).
  - match_count = number of matching entries.
  - found = (match_count != 0); match_idx = lowest matching index.
  - match_count resets to 0 and updates only at done.
- Undefined: port absent; early-exit behaviour as described above.

Test Plan:
- Entry i = i, n=10, arg_id=1, start at E0 -> done after E0+2, found=1, match_idx=1; done low one cycle later.
- Same table, arg_id=12 -> done after E0+10, found=0, match_idx=0; busy high for cycles E0..E0+9.
- num_entries=0 -> done after E0, found=0, busy never high; num_entries=15 with arg_id=9 -> clamped to 10, found=1, match_idx=9.
- Entries 3 and 7 both = 6, arg_id=6 -> match_idx=3.
  - With SINK_SEARCH_MATCH_COUNT_EN: match_count=2, done after E0+10.
- abort at E0+3 with arg_id=8 -> IDLE, no done; start re-pulsed while in SCAN ignored; reset at E0+4 -> all outputs 0 immediately.
- Back-to-back: new start (arg_id=0) held high in the done cycle -> accepted; second done after 1 further cycle, found=1, match_idx=0.

Source files
------------

// File: rtl/sink_table_search_if.sv
// Search request/result bundle for sink_table_search; the master launches, the slave scans.
// match_count exists only when SINK_SEARCH_MATCH_COUNT_EN is defined.
interface sink_table_search_if #(
  parameter int ID_W  = 5,
  parameter int DEPTH = 10,
  parameter int IDX_W = 4,
  parameter int CNT_W = 4
);
  logic                  start;
  logic                  abort;
  logic [ID_W-1:0]       arg_id;
  logic [DEPTH*ID_W-1:0] table_flat;
  logic [CNT_W-1:0]      num_entries;
  logic                  busy;
  logic                  done;
  logic                  found;
  logic [IDX_W-1:0]      match_idx;
`ifdef SINK_SEARCH_MATCH_COUNT_EN
  logic [CNT_W-1:0]      match_count;

  modport master (
    output start, abort, arg_id, table_flat, num_entries,
    input  busy, done, found, match_idx, match_count
  );
  modport slave (
    input  start, abort, arg_id, table_flat, num_entries,
    output busy, done, found, match_idx, match_count
  );
`else
  modport master (
    output start, abort, arg_id, table_flat, num_entries,
    input  busy, done, found, match_idx
  );
  modport slave (
    input  start, abort, arg_id, table_flat, num_entries,
    output busy, done, found, match_idx
  );
`endif
endinterface

// File: rtl/sink_table_search.sv
// Sequential sink-ID lookup, one table entry per clock; done pulses one cycle after the deciding edge.
// No backpressure: start is only taken in IDLE. SINK_SEARCH_MATCH_COUNT_EN scans all entries and counts matches.
module sink_table_search #(
  parameter int ID_W  = 5,
  parameter int DEPTH = 10,
  parameter int IDX_W = 4,
  parameter int CNT_W = 4
) (
  input logic               clock,
  input logic               reset,
  sink_table_search_if.slave bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                state;
  logic [ID_W-1:0]       arg_q;
  logic [DEPTH*ID_W-1:0] tbl_q;
  logic [CNT_W-1:0]      n_q;
  logic [IDX_W-1:0]      idx;
  logic                  busy_r;
  logic                  done_r;
  logic                  found_r;
  logic [IDX_W-1:0]      midx_r;

  logic [CNT_W-1:0]      n_in;
  logic [ID_W-1:0]       entry;
  logic                  hit;
  logic                  last;

  // Clamp once at launch so the scan bound never exceeds the table.
  assign n_in  = (bus.num_entries > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : bus.num_entries;
  assign entry = tbl_q[ID_W*idx +: ID_W];
  assign hit   = (entry == arg_q);
  assign last  = (CNT_W'(idx) == n_q - CNT_W'(1));

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.found     = found_r;
  assign bus.match_idx = midx_r;

`ifdef SINK_SEARCH_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_acc;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] mcnt_r;
  logic             first_vld;
  logic [IDX_W-1:0] first_idx;

  assign cnt_next        = cnt_acc + CNT_W'(hit);
  assign bus.match_count = mcnt_r;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      arg_q   <= '0;
      tbl_q   <= '0;
      n_q     <= '0;
      idx     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      found_r <= 1'b0;
      midx_r  <= '0;
`ifdef SINK_SEARCH_MATCH_COUNT_EN
      cnt_acc   <= '0;
      mcnt_r    <= '0;
      first_vld <= 1'b0;
      first_idx <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            arg_q <= bus.arg_id;
            tbl_q <= bus.table_flat;
            n_q   <= n_in;
            idx   <= '0;
`ifdef SINK_SEARCH_MATCH_COUNT_EN
            cnt_acc   <= '0;
            first_vld <= 1'b0;
            first_idx <= '0;
`endif
            if (n_in == '0) begin
              done_r  <= 1'b1;
              found_r <= 1'b0;
              midx_r  <= '0;
`ifdef SINK_SEARCH_MATCH_COUNT_EN
              mcnt_r  <= '0;
`endif
            end else begin
              busy_r <= 1'b1;
              state  <= SCAN;
            end
          end
        end
        SCAN: begin
          // Abort outranks a result landing on the same edge; prior results are kept.
          if (bus.abort) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
`ifdef SINK_SEARCH_MATCH_COUNT_EN
          else begin
            cnt_acc <= cnt_next;
            if (hit && !first_vld) begin
              first_vld <= 1'b1;
              first_idx <= idx;
            end
            if (last) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state   <= IDLE;
              mcnt_r  <= cnt_next;
              found_r <= (cnt_next != '0);
              midx_r  <= first_vld ? first_idx : (hit ? idx : '0);
            end else begin
              idx <= idx + 1'b1;
            end
          end
`else
          else if (hit) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state   <= IDLE;
            found_r <= 1'b1;
            midx_r  <= idx;
          end else if (last) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state   <= IDLE;
            found_r <= 1'b0;
            midx_r  <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sink_table_search.sv
// Scoreboard bench for sink_table_search: stimulus queues expected results, a monitor checks each done pulse.
module tb_sink_table_search;
  localparam int ID_W  = 5;
  localparam int DEPTH = 10;
  localparam int IDX_W = 4;
  localparam int CNT_W = 4;

  typedef struct {
    int edge_n;
    int found;
    int idx;
    int cnt;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sink_table_search_if #(.ID_W(ID_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();
  sink_table_search #(.ID_W(ID_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   edge_cnt = 0;
  int   n_pass   = 0;
  int   n_total  = 0;
  int   last_lat = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
  endtask

  // Cycles from the launch edge to the edge that produces done.
  function automatic int lat(input int f, input int k, input int n);
`ifdef SINK_SEARCH_MATCH_COUNT_EN
    return n;
`else
    return (f != 0) ? k + 1 : n;
`endif
  endfunction

  function automatic logic [DEPTH*ID_W-1:0] mk_seq();
    logic [DEPTH*ID_W-1:0] t;
    for (int i = 0; i < DEPTH; i++) t[ID_W*i +: ID_W] = ID_W'(i);
    return t;
  endfunction

  function automatic logic [DEPTH*ID_W-1:0] mk_dup();
    logic [DEPTH*ID_W-1:0] t;
    for (int i = 0; i < DEPTH; i++) t[ID_W*i +: ID_W] = ID_W'(i + 10);
    t[ID_W*3 +: ID_W] = ID_W'(6);
    t[ID_W*7 +: ID_W] = ID_W'(6);
    return t;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", int'(bus.done), 0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_edge", edge_cnt, mon_e.edge_n);
        chk("found", int'(bus.found), mon_e.found);
        chk("match_idx", int'(bus.match_idx), mon_e.idx);
`ifdef SINK_SEARCH_MATCH_COUNT_EN
        chk("match_count", int'(bus.match_count), mon_e.cnt);
`endif
      end
    end
  end

  task automatic set_start(input logic [ID_W-1:0] id, input logic [DEPTH*ID_W-1:0] tbl,
                           input int num, input bit push, input int f, input int k, input int cnt);
    exp_t e;
    int   n;
    bus.start       = 1'b1;
    bus.arg_id      = id;
    bus.table_flat  = tbl;
    bus.num_entries = CNT_W'(num);
    n        = (num > DEPTH) ? DEPTH : num;
    last_lat = lat(f, k, n);
    if (push) begin
      e.edge_n = edge_cnt + 1 + last_lat;
      e.found  = f;
      e.idx    = (f != 0) ? k : 0;
      e.cnt    = cnt;
      sb.push_back(e);
    end
  endtask

  task automatic launch(input logic [ID_W-1:0] id, input logic [DEPTH*ID_W-1:0] tbl,
                        input int num, input bit push, input int f, input int k, input int cnt);
    @(negedge clock);
    set_start(id, tbl, num, push, f, k, cnt);
  endtask

  // Drops start, scrambles the input buses, and waits for the queue to drain while counting busy cycles.
  task automatic run_wait(input string name);
    int bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (i == 0) begin
        bus.start      = 1'b0;
        bus.arg_id     = ~bus.arg_id;
        bus.table_flat = {DEPTH{bus.arg_id}};
      end
      if (bus.busy === 1'b1) bc++;
      #1;
      if (sb.size() == 0) break;
    end
    chk({name, "_pending"}, sb.size(), 0);
    chk({name, "_busy_cycles"}, bc, last_lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DEPTH*ID_W-1:0] seq;
    logic [DEPTH*ID_W-1:0] dup;
    seq = mk_seq();
    dup = mk_dup();
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.arg_id      = '0;
    bus.table_flat  = '0;
    bus.num_entries = '0;

    repeat (2) @(negedge clock);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_found", int'(bus.found), 0);
    chk("rst_match_idx", int'(bus.match_idx), 0);
    reset = 1'b0;
    @(negedge clock);

    // Match at entry 1
    launch(ID_W'(1), seq, 10, 1, 1, 1, 1);
    run_wait("t1");
    @(negedge clock);
    chk("t1_done_cleared", int'(bus.done), 0);
    chk("t1_found_hold", int'(bus.found), 1);

    // Back-to-back: new start held in the done cycle
    launch(ID_W'(1), seq, 10, 1, 1, 1, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (i == 0) bus.start = 1'b0;
      if (bus.done === 1'b1) break;
    end
    set_start(ID_W'(0), seq, 10, 1, 1, 0, 1);
    run_wait("b2b");

    // Full miss
    launch(ID_W'(12), seq, 10, 1, 0, 0, 0);
    run_wait("t2");

    // Empty table
    launch(ID_W'(3), seq, 0, 1, 0, 0, 0);
    run_wait("t3");

    // Oversized count is clamped to DEPTH
    launch(ID_W'(9), seq, 15, 1, 1, 9, 1);
    run_wait("t4");

    // Duplicates: lowest index wins
    launch(ID_W'(6), dup, 10, 1, 1, 3, 2);
    run_wait("t5");

    // Abort mid-scan, with an ignored start re-pulse while scanning
    launch(ID_W'(8), seq, 10, 0, 1, 8, 1);
    @(negedge clock);
    chk("abort_busy_scan", int'(bus.busy), 1);
    bus.arg_id = ID_W'(2);
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_found_kept", int'(bus.found), 1);
    chk("abort_idx_kept", int'(bus.match_idx), 3);
    repeat (15) @(negedge clock);
    chk("abort_idle", int'(bus.busy), 0);

    // Asynchronous reset mid-scan
    launch(ID_W'(12), seq, 10, 0, 0, 0, 0);
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_found", int'(bus.found), 0);
    chk("mid_rst_match_idx", int'(bus.match_idx), 0);
`ifdef SINK_SEARCH_MATCH_COUNT_EN
    chk("mid_rst_match_count", int'(bus.match_count), 0);
`endif
    @(negedge clock);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    chk("post_rst_busy", int'(bus.busy), 0);

    // Search still works after reset
    launch(ID_W'(5), seq, 10, 1, 1, 5, 1);
    run_wait("t6");

    repeat (4) @(negedge clock);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
